ifu_prefetch: RTL and testbench

Parametrised successor to the single-request fetch stage. It keeps up to MAX_OUTSTANDING AXI-lite read requests in flight and streams the returned instructions through a FIFO_DEPTH-entry prefetch buffer to the decode stage over a valid/ready handshake. Redirects (branch, exception, xret), already resolved to a target PC upstream, flush the buffer and discard stale in-flight responses. The block sits between the writeback-side redirect logic and the instruction memory port.

---
 rtl/ifu_prefetch.sv | 164 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: AXI-lite instruction prefetcher with multiple requests in flight and a FIFO_DEPTH-entry buffer.
// Optional performance counters are compiled in when IFU_PREFETCH_PERF_EN is defined.
module ifu_prefetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] araddr_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rresp_i,
  input  logic            rvalid_i,
  output logic            rready_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_snpc_o,
  output logic            inst_fault_o
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_drop_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]     MAX_C   = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;

  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic            fault_mem[FIFO_DEPTH];

  logic [CW:0] inflight_sum;
  logic [CW:0] occupancy_sum;
  logic        ar_fire, beat_drop, beat_push, push_en, pop;

  // Every accepted request reserves a buffer slot, so a returning beat never finds the buffer full.
  assign inflight_sum  = {1'b0, outstanding_reg} + {1'b0, drop_reg};
  assign occupancy_sum = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign arvalid_o     = !reset && !redirect_valid_i &&
                         (inflight_sum < MAX_C) && (occupancy_sum < DEPTH_C);
  assign araddr_o      = fetch_pc_reg;
  assign rready_o      = 1'b1;
  assign ar_fire       = arvalid_o && arready_i;

  // A beat with nothing outstanding is unsolicited and is discarded rather than overfilling the buffer.
  assign beat_drop = rvalid_i && (drop_reg != '0);
  assign beat_push = rvalid_i && (drop_reg == '0) && (outstanding_reg != '0);
  assign push_en   = beat_push && !redirect_valid_i && !reset;

  assign inst_valid_o = !reset && (count_reg != '0);
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = data_mem[rd_ptr_reg];
  assign inst_pc_o    = pc_mem[rd_ptr_reg];
  assign inst_snpc_o  = pc_mem[rd_ptr_reg] + FOUR;
  assign inst_fault_o = fault_mem[rd_ptr_reg];

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    if (redirect_valid_i) begin
      // Everything still in flight becomes stale; a beat landing this cycle already pays off one of them.
      fetch_pc_next    = redirect_pc_i;
      resp_pc_next     = redirect_pc_i;
      outstanding_next = '0;
      count_next       = '0;
      rd_ptr_next      = '0;
      wr_ptr_next      = '0;
      drop_next        = CW'(inflight_sum - {{CW{1'b0}}, rvalid_i && (inflight_sum != '0)});
    end else begin
      if (ar_fire)
        fetch_pc_next = fetch_pc_reg + FOUR;
      if (beat_drop)
        drop_next = drop_reg - CW'(1);
      if (beat_push) begin
        resp_pc_next = resp_pc_reg + FOUR;
        wr_ptr_next  = wr_ptr_reg + PW'(1);
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + PW'(1);
      outstanding_next = outstanding_reg + CW'(ar_fire) - CW'(beat_push);
      count_next       = count_reg + CW'(beat_push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      data_mem[wr_ptr_reg]  <= rdata_i;
      fault_mem[wr_ptr_reg] <= |rresp_i;
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_reg, perf_drop_reg, perf_stall_reg;
  logic        beat_discard;

  assign beat_discard = rvalid_i && !push_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_reg <= '0;
      perf_drop_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (ar_fire && (perf_fetch_reg != '1))
        perf_fetch_reg <= perf_fetch_reg + 32'd1;
      if (beat_discard && (perf_drop_reg != '1))
        perf_drop_reg <= perf_drop_reg + 32'd1;
      if (!inst_valid_o && inst_ready_i && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_reg;
  assign perf_drop_o  = perf_drop_reg;
  assign perf_stall_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: in-order memory model with variable latency and a
// sequential-PC reference that restarts at every redirect target.
module tb_ifu_prefetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          MAX_OUT  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o, inst_pc_o, inst_snpc_o;
  logic        inst_fault_o;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_o, perf_drop_o, perf_stall_o;
`endif

  always #5 clock = ~clock;

  ifu_prefetch dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .araddr_o        (araddr_o),
    .arvalid_o       (arvalid_o),
    .arready_i       (arready_i),
    .rdata_i         (rdata_i),
    .rresp_i         (rresp_i),
    .rvalid_i        (rvalid_i),
    .rready_o        (rready_o),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_snpc_o     (inst_snpc_o),
    .inst_fault_o    (inst_fault_o)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetch_o    (perf_fetch_o),
    .perf_drop_o     (perf_drop_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [96:0] pop_q[$];      // {pc, inst, snpc, fault} of every accepted pop
  logic [31:0] ar_log[$];
  int          cyc = 0, lat = 1, last_due = 0;
  int          inflight = 0, max_inflight = 0, ar_count = 0;
  int          n_checks = 0, n_fail = 0;
  bit          rst_req = 1'b1;
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  logic        obs_arvalid, obs_inst_valid, obs_rvalid;
  logic [31:0] obs_araddr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [96:0] expect_entry(input logic [31:0] pc);
    return {pc, mem_data(pc), pc + 32'd4, fault_en && (pc == fault_addr)};
  endfunction

  // One clock cycle: drive inputs after the falling edge, observe, log the handshakes that the next rising edge takes.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit iready, input bit aready);
    req_t r;
    int   d;
    @(negedge clock);
    reset            = rst_req;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    inst_ready_i     = iready;
    arready_i        = aready;
    rvalid_i         = 1'b0;
    rdata_i          = '0;
    rresp_i          = 2'b00;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r        = mem_q.pop_front();
      rvalid_i = 1'b1;
      rdata_i  = mem_data(r.addr);
      rresp_i  = (fault_en && r.addr == fault_addr) ? 2'b10 : 2'b00;
      inflight--;
    end
    #1;
    obs_arvalid    = arvalid_o;
    obs_araddr     = araddr_o;
    obs_inst_valid = inst_valid_o;
    obs_rvalid     = rvalid_i;
    if (arvalid_o && arready_i) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: araddr_o, due: d});
      ar_log.push_back(araddr_o);
      inflight++;
      ar_count++;
    end
    if (inflight > max_inflight) max_inflight = inflight;
    if (inst_valid_o && inst_ready_i && !redirect_valid_i)
      pop_q.push_back({inst_pc_o, inst_o, inst_snpc_o, inst_fault_o});
    cyc++;
  endtask

  task automatic do_reset();
    mem_q.delete();
    rst_req = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    rst_req      = 1'b0;
    inflight     = 0;
    max_inflight = 0;
    ar_count     = 0;
    last_due     = cyc;
    fault_en     = 1'b0;
    lat          = 1;
    ar_log.delete();
    pop_q.delete();
  endtask

  task automatic test_reset();
    rst_req = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (obs_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", obs_arvalid); end
    n_checks++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", obs_inst_valid); end
    n_checks++; if (rready_o !== 1'b1) begin n_fail++; $display("FAIL reset_rready: got %b expected 1", rready_o); end
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (obs_arvalid !== 1'b1) begin n_fail++; $display("FAIL release_arvalid: got %b expected 1", obs_arvalid); end
    n_checks++; if (obs_araddr !== RESET_PC) begin n_fail++; $display("FAIL release_araddr: got %h expected %h", obs_araddr, RESET_PC); end
    n_checks++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("FAIL release_inst_valid: got %b expected 0", obs_inst_valid); end
    $display("test_reset done: %0d checks so far", n_checks);
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [96:0] got;
    do_reset();
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (pop_q.size() < 3) begin n_fail++; $display("FAIL stream_count: got %0d pops expected >= 3", pop_q.size()); end
    exp_pc = RESET_PC;
    while (pop_q.size() > 0) begin
      got = pop_q.pop_front();
      n_checks++;
      if (got !== expect_entry(exp_pc)) begin
        n_fail++; $display("FAIL stream_entry: got %h expected %h", got, expect_entry(exp_pc));
      end
      exp_pc += 32'd4;
    end
    n_checks++; if (max_inflight > MAX_OUT) begin n_fail++; $display("FAIL stream_outstanding: got %0d expected <= %0d", max_inflight, MAX_OUT); end
    $display("test_stream done: delivered up to pc %h", exp_pc - 32'd4);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    logic [96:0] got;
    do_reset();
    repeat (20) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (pop_q.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops expected 0", pop_q.size()); end
    n_checks++; if (ar_count != 4) begin n_fail++; $display("FAIL bp_ar_count: got %0d expected 4", ar_count); end
    n_checks++; if (obs_arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_arvalid: got %b expected 0", obs_arvalid); end
    n_checks++; if (obs_inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_inst_valid: got %b expected 1", obs_inst_valid); end
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (pop_q.size() < 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d pops expected >= 4", pop_q.size()); end
    exp_pc = RESET_PC;
    while (pop_q.size() > 0) begin
      got = pop_q.pop_front();
      n_checks++;
      if (got !== expect_entry(exp_pc)) begin
        n_fail++; $display("FAIL bp_entry: got %h expected %h", got, expect_entry(exp_pc));
      end
      exp_pc += 32'd4;
    end
    $display("test_backpressure done: drained through pc %h", exp_pc - 32'd4);
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    logic [96:0] got;
    int          ar_mark;
    do_reset();
    lat = 4;
    for (int i = 0; i < 10 && inflight < 2; i++) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (inflight != 2) begin n_fail++; $display("FAIL redir_setup_inflight: got %0d expected 2", inflight); end
    ar_mark = ar_count;
    step(1'b1, 32'h8000_1000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_inst_valid: got %b expected 0", obs_inst_valid); end
    repeat (25) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (ar_log.size() <= ar_mark || ar_log[ar_mark] !== 32'h8000_1000) begin
      n_fail++; $display("FAIL redir_first_ar: got %0d requests after redirect, expected first at 80001000", ar_log.size() - ar_mark);
    end
    n_checks++; if (pop_q.size() < 2) begin n_fail++; $display("FAIL redir_count: got %0d pops expected >= 2", pop_q.size()); end
    exp_pc = 32'h8000_1000;
    while (pop_q.size() > 0) begin
      got = pop_q.pop_front();
      n_checks++;
      if (got !== expect_entry(exp_pc)) begin
        n_fail++; $display("FAIL redir_entry: got %h expected %h", got, expect_entry(exp_pc));
      end
      exp_pc += 32'd4;
    end
    $display("test_redirect done: delivered through pc %h", exp_pc - 32'd4);
  endtask

  task automatic test_fault();
    logic [31:0] exp_pc;
    logic [96:0] got;
    int          n_pop;
    do_reset();
    fault_en   = 1'b1;
    fault_addr = RESET_PC + 32'd8;
    repeat (20) step(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (15) step(1'b0, '0, 1'b1, 1'b1);
    n_pop = pop_q.size();
    n_checks++; if (n_pop < 4) begin n_fail++; $display("FAIL fault_count: got %0d pops expected >= 4", n_pop); end
    exp_pc = RESET_PC;
    while (pop_q.size() > 0) begin
      got = pop_q.pop_front();
      n_checks++;
      if (got !== expect_entry(exp_pc)) begin
        n_fail++; $display("FAIL fault_entry: got %h expected %h", got, expect_entry(exp_pc));
      end
      exp_pc += 32'd4;
    end
    $display("test_fault done: %0d entries checked", n_pop);
  endtask

  task automatic test_arready_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs_arvalid !== 1'b1 || obs_araddr !== RESET_PC) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got arvalid=%b araddr=%h expected 1 %h", i, obs_arvalid, obs_araddr, RESET_PC);
      end
    end
    n_checks++; if (ar_count != 0) begin n_fail++; $display("FAIL stall_no_ar: got %0d expected 0", ar_count); end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (ar_count != 1) begin n_fail++; $display("FAIL stall_one_ar: got %0d expected 1", ar_count); end
    n_checks++;
    if (obs_arvalid !== 1'b1 || obs_araddr !== RESET_PC + 32'd4) begin
      n_fail++; $display("FAIL stall_next_addr: got arvalid=%b araddr=%h expected 1 %h", obs_arvalid, obs_araddr, RESET_PC + 32'd4);
    end
    $display("test_arready_stall done: %0d requests issued", ar_count);
  endtask

  task automatic test_redirect_collision();
    logic [31:0] exp_pc;
    logic [96:0] got;
    int          ar_mark;
    do_reset();
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    ar_mark = ar_count;
    step(1'b1, 32'h8000_2040, 1'b1, 1'b1);
    n_checks++; if (obs_rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_setup_beat: got %b expected 1", obs_rvalid); end
    n_checks++; if (obs_inst_valid !== 1'b1) begin n_fail++; $display("FAIL coll_head_valid: got %b expected 1", obs_inst_valid); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (obs_inst_valid !== 1'b0) begin n_fail++; $display("FAIL coll_empty: got %b expected 0", obs_inst_valid); end
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (ar_log.size() <= ar_mark || ar_log[ar_mark] !== 32'h8000_2040) begin
      n_fail++; $display("FAIL coll_first_ar: got %0d requests after redirect, expected first at 80002040", ar_log.size() - ar_mark);
    end
    n_checks++; if (pop_q.size() < 2) begin n_fail++; $display("FAIL coll_count: got %0d pops expected >= 2", pop_q.size()); end
    exp_pc = 32'h8000_2040;
    while (pop_q.size() > 0) begin
      got = pop_q.pop_front();
      n_checks++;
      if (got !== expect_entry(exp_pc)) begin
        n_fail++; $display("FAIL coll_entry: got %h expected %h", got, expect_entry(exp_pc));
      end
      exp_pc += 32'd4;
    end
    $display("test_redirect_collision done: delivered through pc %h", exp_pc - 32'd4);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    logic [96:0] got;
    bit          redir;
    int          n_pop = 0, n_redir = 0;
    do_reset();
    fault_en   = 1'b1;
    fault_addr = RESET_PC + 32'(4 * $urandom_range(2, 12));
    exp_pc     = RESET_PC;
    for (int c = 0; c < 3000; c++) begin
      lat   = $urandom_range(1, 4);
      redir = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = RESET_PC + 32'(4 * $urandom_range(0, 16));
        1:       tgt = 32'hFFFF_FFF0;
        default: tgt = $urandom() & 32'hFFFF_FFFC;
      endcase
      step(redir, tgt, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      while (pop_q.size() > 0) begin
        got = pop_q.pop_front();
        n_pop++;
        n_checks++;
        if (got !== expect_entry(exp_pc)) begin
          n_fail++; $display("FAIL random_entry: got %h expected %h", got, expect_entry(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (redir) begin
        exp_pc = tgt;
        n_redir++;
      end
    end
    n_checks++; if (n_pop < 100) begin n_fail++; $display("FAIL random_progress: got %0d pops expected >= 100", n_pop); end
    n_checks++; if (max_inflight > MAX_OUT) begin n_fail++; $display("FAIL random_outstanding: got %0d expected <= %0d", max_inflight, MAX_OUT); end
    $display("test_random done: %0d pops, %0d redirects", n_pop, n_redir);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_arready_stall();
    test_redirect_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
